// File: rtl/fifo_32x8_if.sv
// Producer/consumer-side bundle for fifo_32x8: requests, data and status flags.
interface fifo_32x8_if #(
  parameter int unsigned tam  = 32,
  parameter int unsigned size = 8
);

  localparam int unsigned UW = $clog2(tam - 1);

  logic            READ;
  logic            WRITE;
  logic [size-1:0] DATA_IN;
  logic [size-1:0] DATA_OUT;
  logic            F_FULL_N;
  logic            F_EMPTY_N;
  logic [UW-1:0]   USE_DW;

  // User side: issues requests and observes data and flags.
  modport master (
    output READ,
    output WRITE,
    output DATA_IN,
    input  DATA_OUT,
    input  F_FULL_N,
    input  F_EMPTY_N,
    input  USE_DW
  );

  // FIFO side: accepts requests and drives data and flags.
  modport slave (
    input  READ,
    input  WRITE,
    input  DATA_IN,
    output DATA_OUT,
    output F_FULL_N,
    output F_EMPTY_N,
    output USE_DW
  );

endinterface

// File: rtl/fifo_32x8.sv
// Single-clock FIFO, tam x size, with registered read data, active-low
// full/empty flags and a used-word count that wraps to 0 when full.
module fifo_32x8 #(
  parameter int unsigned tam  = 32,
  parameter int unsigned size = 8
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          CLEAR_N,
  fifo_32x8_if.slave    bus
);

  localparam int unsigned AW = $clog2(tam);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned UW = $clog2(tam - 1);

  // Storage and pointers
  logic [size-1:0] mem [tam];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  // Registered outputs
  logic [size-1:0] data_out_q;
  logic            full_n_q;
  logic            empty_n_q;
  logic [UW-1:0]   use_dw_q;

  // Request qualification and next occupancy
  logic            empty_c;
  logic            full_c;
  logic            rd_acc_c;
  logic            wr_acc_c;
  logic [CW-1:0]   count_nxt_c;

  // Accept logic: a read frees a slot, so a full FIFO can take a write alongside it.
  always_comb begin
    empty_c     = (count == '0);
    full_c      = (count == CW'(tam));
    rd_acc_c    = bus.READ && !empty_c;
    wr_acc_c    = bus.WRITE && (!full_c || rd_acc_c);
    count_nxt_c = count;
    if (wr_acc_c && !rd_acc_c) begin
      count_nxt_c = count + CW'(1);
    end else if (rd_acc_c && !wr_acc_c) begin
      count_nxt_c = count - CW'(1);
    end
  end

  // Control state, read data and flags; flags are registered from the next count.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out_q <= '0;
      full_n_q   <= 1'b1;
      empty_n_q  <= 1'b0;
      use_dw_q   <= '0;
    end else if (!CLEAR_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out_q <= '0;
      full_n_q   <= 1'b1;
      empty_n_q  <= 1'b0;
      use_dw_q   <= '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc_c) begin
        rd_ptr     <= rd_ptr + AW'(1);
        data_out_q <= mem[rd_ptr];
      end
      count     <= count_nxt_c;
      full_n_q  <= (count_nxt_c != CW'(tam));
      empty_n_q <= (count_nxt_c != '0);
      use_dw_q  <= count_nxt_c[UW-1:0];
    end
  end

  // Storage array; not reset, stale words are unreachable once the pointers clear.
  always_ff @(posedge CLOCK) begin
    if (CLEAR_N && wr_acc_c) begin
      mem[wr_ptr] <= bus.DATA_IN;
    end
  end

  assign bus.DATA_OUT  = data_out_q;
  assign bus.F_FULL_N  = full_n_q;
  assign bus.F_EMPTY_N = empty_n_q;
  assign bus.USE_DW    = use_dw_q;

endmodule

// File: tb/tb_fifo_32x8.sv
// Bench for fifo_32x8: queue-based reference model plus a scoreboard of
// expected read data, checked after every clock edge.
module tb_fifo_32x8;

  localparam int unsigned TAM  = 32;
  localparam int unsigned SIZE = 8;

  logic CLOCK;
  logic RESET_N;
  logic CLEAR_N;

  fifo_32x8_if #(.tam(TAM), .size(SIZE)) bus ();

  fifo_32x8 #(.tam(TAM), .size(SIZE)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .CLEAR_N (CLEAR_N),
    .bus     (bus)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_errors = 0;

  logic [SIZE-1:0] mdl_q [$];
  logic [SIZE-1:0] exp_q [$];
  logic [SIZE-1:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs against the reference model.
  task automatic check_state(input string tag);
    int n;
    n = mdl_q.size();
    check({tag, "_dout"},    32'(bus.DATA_OUT),  32'(exp_dout));
    check({tag, "_empty_n"}, 32'(bus.F_EMPTY_N), 32'(n != 0));
    check({tag, "_full_n"},  32'(bus.F_FULL_N),  32'(n != TAM));
    check({tag, "_use_dw"},  32'(bus.USE_DW),    32'(n % TAM));
  endtask

  // One clock: drive on the falling edge, update the model, sample just after the rising edge.
  task automatic do_op(input string tag, input logic rd, input logic wr,
                       input logic [SIZE-1:0] din, input logic clr);
    logic rd_ok;
    logic wr_ok;
    @(negedge CLOCK);
    bus.READ    = rd;
    bus.WRITE   = wr;
    bus.DATA_IN = din;
    CLEAR_N     = !clr;
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    if (clr) begin
      mdl_q.delete();
      exp_q.delete();
      exp_dout = '0;
    end else begin
      rd_ok = rd && (mdl_q.size() > 0);
      wr_ok = wr && ((mdl_q.size() < TAM) || rd_ok);
      if (rd_ok) exp_q.push_back(mdl_q.pop_front());
      if (wr_ok) mdl_q.push_back(din);
    end
    @(posedge CLOCK);
    #1;
    if (rd_ok && exp_q.size() > 0) exp_dout = exp_q.pop_front();
    check_state(tag);
  endtask

  task automatic idle_inputs();
    @(negedge CLOCK);
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
    CLEAR_N   = 1'b1;
  endtask

  initial begin
    bus.READ    = 1'b0;
    bus.WRITE   = 1'b0;
    bus.DATA_IN = '0;
    CLEAR_N     = 1'b1;
    RESET_N     = 1'b0;
    exp_dout    = '0;
    repeat (2) @(posedge CLOCK);
    #1;
    check_state("reset");
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Simultaneous read/write on empty: only the write lands.
    do_op("rw_empty", 1'b1, 1'b1, 8'hAA, 1'b0);
    check("rw_empty_dout_held", 32'(bus.DATA_OUT), 32'h00);
    check("rw_empty_use_dw", 32'(bus.USE_DW), 32'd1);
    do_op("drain_aa", 1'b1, 1'b0, 8'h00, 1'b0);
    check("drain_aa_val", 32'(bus.DATA_OUT), 32'hAA);

    // Ten writes then ten reads, plus a read on empty.
    for (int i = 1; i <= 10; i++) do_op("wr10", 1'b0, 1'b1, 8'(i), 1'b0);
    check("wr10_use_dw", 32'(bus.USE_DW), 32'd10);
    for (int i = 1; i <= 10; i++) do_op("rd10", 1'b1, 1'b0, 8'h00, 1'b0);
    check("rd10_last", 32'(bus.DATA_OUT), 32'h0A);
    check("rd10_empty", 32'(bus.F_EMPTY_N), 32'd0);
    do_op("rd_on_empty", 1'b1, 1'b0, 8'h00, 1'b0);
    check("rd_on_empty_hold", 32'(bus.DATA_OUT), 32'h0A);

    // Overfill: 36 writes, last four dropped.
    for (int i = 1; i <= 36; i++) begin
      do_op("fill", 1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 32) begin
        check("fill32_full_n", 32'(bus.F_FULL_N), 32'd0);
        check("fill32_use_dw", 32'(bus.USE_DW), 32'd0);
      end
    end

    // Read and write together while full.
    do_op("rw_full", 1'b1, 1'b1, 8'hAA, 1'b0);
    check("rw_full_dout", 32'(bus.DATA_OUT), 32'h01);
    check("rw_full_still_full", 32'(bus.F_FULL_N), 32'd0);
    for (int i = 0; i < 32; i++) do_op("drain_full", 1'b1, 1'b0, 8'h00, 1'b0);
    check("drain_full_last", 32'(bus.DATA_OUT), 32'hAA);
    check("drain_full_empty", 32'(bus.F_EMPTY_N), 32'd0);

    // Synchronous clear after a few writes.
    for (int i = 0; i < 5; i++) do_op("pre_clr", 1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
    do_op("clear", 1'b1, 1'b1, 8'h77, 1'b1);
    check("clear_dout", 32'(bus.DATA_OUT), 32'h00);
    check("clear_empty_n", 32'(bus.F_EMPTY_N), 32'd0);
    idle_inputs();

    // Pointer wrap: two rounds of 20 in, 20 out.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) do_op("wrap_wr", 1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 20; i++) do_op("wrap_rd", 1'b1, 1'b0, 8'h00, 1'b0);
    end

    // Mixed random traffic against the model.
    for (int i = 0; i < 200; i++)
      do_op("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 40) == 0));

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 7; i++) do_op("burst", 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    mdl_q.delete();
    exp_q.delete();
    exp_dout = '0;
    check_state("async_rst");
    @(negedge CLOCK);
    bus.WRITE = 1'b0;
    bus.READ  = 1'b0;
    RESET_N   = 1'b1;
    do_op("post_rst_wr", 1'b0, 1'b1, 8'h3C, 1'b0);
    do_op("post_rst_rd", 1'b1, 1'b0, 8'h00, 1'b0);
    check("post_rst_val", 32'(bus.DATA_OUT), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
